// File: rtl/fifo_frame_reader_if.sv
// Bundles the FIFO read side and the outgoing byte stream of fifo_frame_reader.
// The master modport is the frame reader; the slave side is the FIFO plus the downstream sink.
interface fifo_frame_reader_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_rd_vld;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_sop;
  logic              m_eop;

  modport master (
    input  fifo_rd_data, fifo_rd_vld, m_ready,
    output fifo_rd_en, m_data, m_valid, m_sop, m_eop
  );

  modport slave (
    output fifo_rd_data, fifo_rd_vld, m_ready,
    input  fifo_rd_en, m_data, m_valid, m_sop, m_eop
  );
endinterface

// File: rtl/fifo_frame_reader.sv
// Drains a first-word-fall-through FIFO into fixed-length frames (HDR0, HDR1, SEQ, payload, CHK)
// on a valid/ready byte stream; a starved payload is completed with pad bytes after a timeout.
module fifo_frame_reader #(
  parameter int                DATA_W    = 8,
  parameter int                FRAME_LEN = 64,
  parameter int                LEN_W     = 11,
  parameter int                TIMEOUT   = 255,
  parameter logic [DATA_W-1:0] HDR0      = 8'h55,
  parameter logic [DATA_W-1:0] HDR1      = 8'hAA,
  parameter logic [DATA_W-1:0] PAD_BYTE  = 8'h00
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  fifo_frame_reader_if.master bus,
  output logic                busy,
  output logic                pad_event,
  output logic [15:0]         frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_SEQ,
    S_PAYLOAD,
    S_PAD,
    S_CHK
  } state_t;

  localparam logic [LEN_W-1:0] CNT_LAST = LEN_W'(FRAME_LEN - 1);
  localparam logic [15:0]      TMR_LAST = 16'(TIMEOUT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] seq;
  logic [DATA_W-1:0] chk;
  logic [LEN_W-1:0]  byte_cnt;
  logic [15:0]       idle_tmr;
  logic              last_byte;

  assign last_byte = (byte_cnt == CNT_LAST);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    bus.fifo_rd_en = 1'b0;
    bus.m_data     = '0;
    bus.m_valid    = 1'b0;
    bus.m_sop      = 1'b0;
    bus.m_eop      = 1'b0;
    pad_event      = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && bus.fifo_rd_vld) state_nxt = S_HDR0;
      end
      S_HDR0: begin
        bus.m_data  = HDR0;
        bus.m_valid = 1'b1;
        bus.m_sop   = 1'b1;
        if (bus.m_ready) state_nxt = S_HDR1;
      end
      S_HDR1: begin
        bus.m_data  = HDR1;
        bus.m_valid = 1'b1;
        if (bus.m_ready) state_nxt = S_SEQ;
      end
      S_SEQ: begin
        bus.m_data  = seq;
        bus.m_valid = 1'b1;
        if (bus.m_ready) state_nxt = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        // Zero-latency pass-through: the FIFO head is the stream byte.
        bus.m_data     = bus.fifo_rd_data;
        bus.m_valid    = bus.fifo_rd_vld;
        bus.fifo_rd_en = bus.fifo_rd_vld & bus.m_ready;
        if (bus.fifo_rd_en && last_byte) begin
          state_nxt = S_CHK;
        end else if (!bus.fifo_rd_vld && (idle_tmr == TMR_LAST)) begin
          state_nxt = S_PAD;
          pad_event = 1'b1;
        end
      end
      S_PAD: begin
        bus.m_data  = PAD_BYTE;
        bus.m_valid = 1'b1;
        if (bus.m_ready && last_byte) state_nxt = S_CHK;
      end
      S_CHK: begin
        bus.m_data  = chk;
        bus.m_valid = 1'b1;
        bus.m_eop   = 1'b1;
        if (bus.m_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Idle timer holds through back-pressure; only an empty FIFO advances it.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq       <= '0;
      frame_cnt <= '0;
      byte_cnt  <= '0;
      idle_tmr  <= '0;
      chk       <= '0;
    end else begin
      case (state)
        S_SEQ: begin
          if (bus.m_ready) begin
            byte_cnt <= '0;
            chk      <= '0;
            idle_tmr <= '0;
          end
        end
        S_PAYLOAD: begin
          if (bus.fifo_rd_en) begin
            chk      <= chk ^ bus.fifo_rd_data;
            byte_cnt <= byte_cnt + 1'b1;
            idle_tmr <= '0;
          end else if (!bus.fifo_rd_vld) begin
            idle_tmr <= idle_tmr + 1'b1;
          end
        end
        S_PAD: begin
          if (bus.m_ready) begin
            chk      <= chk ^ PAD_BYTE;
            byte_cnt <= byte_cnt + 1'b1;
          end
        end
        S_CHK: begin
          if (bus.m_ready) begin
            seq       <= seq + 1'b1;
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Directed bench for fifo_frame_reader: a queue models the FWFT FIFO, a queue captures stream bytes.
module tb_fifo_frame_reader;
  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        busy;
  logic        pad_event;
  logic [15:0] frame_cnt;

  fifo_frame_reader_if bus();

  fifo_frame_reader dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .bus       (bus),
    .busy      (busy),
    .pad_event (pad_event),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] fq[$];
  logic [9:0] ob[$];
  logic [9:0] exp_q[$];
  logic [9:0] st_snap;
  logic [7:0] fill_val = 8'h00;
  int  cyc_no = 0, pops = 0, eops = 0, pad_cnt = 0, pad_cyc = 0, last_pop_cyc = 0;
  int  bad_pop = 0, stall_err = 0, gap_err = 0, prev_sop = 0;
  bit  sop_seen = 1'b0, stalled = 1'b0;

  // One clock: present FIFO head, sample outputs, account for transfers and pops.
  task automatic cyc();
    bus.fifo_rd_vld  = (fq.size() != 0);
    bus.fifo_rd_data = (fq.size() != 0) ? fq[0] : 8'h00;
    #1;
    if (bus.fifo_rd_en && (!bus.fifo_rd_vld || !bus.m_ready)) bad_pop++;
    if (stalled && (!bus.m_valid || {bus.m_eop, bus.m_sop, bus.m_data} != st_snap)) stall_err++;
    if (bus.m_valid && bus.m_ready) begin
      ob.push_back({bus.m_eop, bus.m_sop, bus.m_data});
      if (bus.m_eop) eops++;
      if (bus.m_sop) begin
        if (sop_seen && (cyc_no - prev_sop) != 69) gap_err++;
        sop_seen = 1'b1;
        prev_sop = cyc_no;
      end
    end
    if (pad_event) begin
      pad_cnt++;
      pad_cyc = cyc_no;
    end
    if (bus.fifo_rd_en) begin
      fq.delete(0);
      pops++;
      last_pop_cyc = cyc_no;
    end
    stalled = bus.m_valid && !bus.m_ready && !rst;
    st_snap = {bus.m_eop, bus.m_sop, bus.m_data};
    cyc_no++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_frames(input int n, input int budget, input bit rnd, input bit refill,
                            output bit to);
    int start;
    int k;
    start = eops;
    k = 0;
    while ((eops - start) < n && k < budget) begin
      if (rnd) bus.m_ready = 1'($urandom_range(0, 1));
      if (refill) begin
        while (fq.size() < 128) begin
          fq.push_back(fill_val);
          fill_val++;
        end
      end
      cyc();
      k++;
    end
    to = ((eops - start) < n);
    bus.m_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    bus.m_ready = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    stalled = 1'b0;
  endtask

  function automatic void build_frame(input logic [7:0] s, input logic [7:0] pl[$]);
    logic [7:0] x;
    x = 8'h00;
    exp_q.delete();
    exp_q.push_back({2'b01, 8'h55});
    exp_q.push_back({2'b00, 8'hAA});
    exp_q.push_back({2'b00, s});
    foreach (pl[i]) begin
      exp_q.push_back({2'b00, pl[i]});
      x ^= pl[i];
    end
    exp_q.push_back({2'b10, x});
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 4; i++) fq.push_back(8'(8'hE0 + i));
    rst = 1'b1;
    enable = 1'b1;
    bus.m_ready = 1'b1;
    cyc();
    cyc();
    checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b want=0", bus.m_valid); end
    checks++; if (bus.m_sop !== 1'b0) begin failures++; $display("FAIL reset_m_sop got=%b want=0", bus.m_sop); end
    checks++; if (bus.m_eop !== 1'b0) begin failures++; $display("FAIL reset_m_eop got=%b want=0", bus.m_eop); end
    checks++; if (bus.fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b want=0", bus.fifo_rd_en); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (pad_event !== 1'b0) begin failures++; $display("FAIL reset_pad_event got=%b want=0", pad_event); end
    checks++; if (bus.m_data !== 8'h00) begin failures++; $display("FAIL reset_m_data got=%h want=00", bus.m_data); end
    checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL reset_frame_cnt got=%0d want=0", frame_cnt); end
    rst = 1'b0;
    fq.delete();
    for (int i = 0; i < 5; i++) cyc();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL empty_no_start busy got=%b want=0", busy); end
    enable = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] pl[$];
    bit to;
    int nerr;
    for (int j = 0; j < 64; j++) begin
      fq.push_back(8'(j));
      pl.push_back(8'(j));
    end
    ob.delete();
    enable = 1'b1;
    bus.m_ready = 1'b1;
    run_frames(1, 200, 1'b0, 1'b0, to);
    enable = 1'b0;
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL basic_timeout got=%b want=0", to); end
    build_frame(8'h00, pl);
    nerr = 0;
    foreach (exp_q[i]) if (i >= ob.size() || ob[i] !== exp_q[i]) nerr++;
    checks++; if (ob.size() != 68) begin failures++; $display("FAIL basic_len got=%0d want=68", ob.size()); end
    checks++; if (nerr != 0) begin failures++; $display("FAIL basic_bytes mismatches=%0d want=0", nerr); end
    checks++; if (ob.size() == 68 && ob[67] !== 10'h200) begin failures++; $display("FAIL basic_chk got=%h want=200", ob[67]); end
    checks++; if (frame_cnt !== 16'd1) begin failures++; $display("FAIL basic_frame_cnt got=%0d want=1", frame_cnt); end
    checks++; if (fq.size() != 0) begin failures++; $display("FAIL basic_fifo_left got=%0d want=0", fq.size()); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_random_ready();
    logic [7:0] pl[$];
    bit to;
    int nerr;
    for (int j = 0; j < 64; j++) begin
      fq.push_back(8'(j));
      pl.push_back(8'(j));
    end
    ob.delete();
    stall_err = 0;
    bad_pop = 0;
    enable = 1'b1;
    run_frames(1, 2000, 1'b1, 1'b0, to);
    enable = 1'b0;
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL rand_timeout got=%b want=0", to); end
    build_frame(8'h01, pl);
    nerr = 0;
    foreach (exp_q[i]) if (i >= ob.size() || ob[i] !== exp_q[i]) nerr++;
    checks++; if (nerr != 0 || ob.size() != 68) begin failures++; $display("FAIL rand_bytes mismatches=%0d len=%0d want=0/68", nerr, ob.size()); end
    checks++; if (stall_err != 0) begin failures++; $display("FAIL rand_stall_stable got=%0d want=0", stall_err); end
    checks++; if (bad_pop != 0) begin failures++; $display("FAIL rand_bad_pop got=%0d want=0", bad_pop); end
    checks++; if (frame_cnt !== 16'd2) begin failures++; $display("FAIL rand_frame_cnt got=%0d want=2", frame_cnt); end
  endtask

  task automatic test_timeout_pad();
    logic [7:0] pl[$];
    int start, k, nerr;
    bit pushed;
    for (int j = 1; j <= 10; j++) begin
      fq.push_back(8'(j));
      pl.push_back(8'(j));
    end
    for (int j = 0; j < 54; j++) pl.push_back(8'h00);
    ob.delete();
    pad_cnt = 0;
    pushed = 1'b0;
    enable = 1'b1;
    start = eops;
    k = 0;
    while (eops == start && k < 800) begin
      cyc();
      k++;
      // A byte shows up on the first padding cycle; it must stay queued.
      if (pad_cnt == 1 && !pushed) begin
        fq.push_back(8'h77);
        pushed = 1'b1;
      end
    end
    enable = 1'b0;
    checks++; if (eops == start) begin failures++; $display("FAIL pad_frame_timeout cycles=%0d", k); end
    build_frame(8'h02, pl);
    nerr = 0;
    foreach (exp_q[i]) if (i >= ob.size() || ob[i] !== exp_q[i]) nerr++;
    checks++; if (nerr != 0 || ob.size() != 68) begin failures++; $display("FAIL pad_bytes mismatches=%0d len=%0d want=0/68", nerr, ob.size()); end
    checks++; if (ob.size() == 68 && ob[67] !== 10'h20B) begin failures++; $display("FAIL pad_chk got=%h want=20B", ob[67]); end
    checks++; if (pad_cnt != 1) begin failures++; $display("FAIL pad_event_count got=%0d want=1", pad_cnt); end
    checks++; if ((pad_cyc - last_pop_cyc) != 255) begin failures++; $display("FAIL pad_event_delay got=%0d want=255", pad_cyc - last_pop_cyc); end
    checks++; if (fq.size() != 1 || fq[0] !== 8'h77) begin failures++; $display("FAIL pad_late_byte fifo_size=%0d want=1", fq.size()); end
    checks++; if (frame_cnt !== 16'd3) begin failures++; $display("FAIL pad_frame_cnt got=%0d want=3", frame_cnt); end
    fq.delete();
  endtask

  task automatic test_back_to_back();
    logic [7:0] pl[$];
    bit to;
    int nerr, lerr;
    do_reset();
    fq.delete();
    ob.delete();
    fill_val = 8'h00;
    sop_seen = 1'b0;
    gap_err = 0;
    enable = 1'b1;
    run_frames(300, 25000, 1'b0, 1'b1, to);
    enable = 1'b0;
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL b2b_timeout frames=%0d want=300", eops); end
    checks++; if (ob.size() != 300 * 68) begin failures++; $display("FAIL b2b_total_len got=%0d want=%0d", ob.size(), 300 * 68); end
    nerr = 0;
    lerr = 0;
    for (int f = 0; f < 300; f++) begin
      pl.delete();
      for (int j = 0; j < 64; j++) pl.push_back(8'(64 * f + j));
      build_frame(8'(f), pl);
      foreach (exp_q[i]) begin
        if ((f * 68 + i) >= ob.size()) lerr++;
        else if (ob[f * 68 + i] !== exp_q[i]) nerr++;
      end
    end
    checks++; if (nerr != 0 || lerr != 0) begin failures++; $display("FAIL b2b_bytes mismatches=%0d missing=%0d want=0", nerr, lerr); end
    checks++; if (ob.size() == 300 * 68 && ob[299 * 68 + 2] !== 10'h02B) begin failures++; $display("FAIL b2b_last_seq got=%h want=02B", ob[299 * 68 + 2]); end
    checks++; if (frame_cnt !== 16'd300) begin failures++; $display("FAIL b2b_frame_cnt got=%0d want=300", frame_cnt); end
    checks++; if (gap_err != 0) begin failures++; $display("FAIL b2b_sop_spacing errors=%0d want=0", gap_err); end
  endtask

  task automatic test_mid_frame_reset();
    logic [7:0] pl[$];
    logic [7:0] head;
    bit to;
    int k, nerr;
    fq.delete();
    ob.delete();
    fill_val = 8'h80;
    enable = 1'b1;
    k = 0;
    while (ob.size() < 23 && k < 100) begin
      while (fq.size() < 128) begin
        fq.push_back(fill_val);
        fill_val++;
      end
      cyc();
      k++;
    end
    checks++; if (ob.size() < 23) begin failures++; $display("FAIL mid_reset_reach got=%0d want=23", ob.size()); end
    rst = 1'b1;
    cyc();
    checks++; if (bus.m_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_reset_idle valid=%b busy=%b want=0/0", bus.m_valid, busy); end
    checks++; if (bus.fifo_rd_en !== 1'b0 || bus.m_eop !== 1'b0 || bus.m_sop !== 1'b0) begin failures++; $display("FAIL mid_reset_ctrl rd_en=%b eop=%b sop=%b want=0", bus.fifo_rd_en, bus.m_eop, bus.m_sop); end
    checks++; if (bus.m_data !== 8'h00 || frame_cnt !== 16'd0) begin failures++; $display("FAIL mid_reset_data data=%h cnt=%0d want=00/0", bus.m_data, frame_cnt); end
    rst = 1'b0;
    stalled = 1'b0;
    head = fq[0];
    ob.delete();
    for (int j = 0; j < 64; j++) pl.push_back(8'(head + j));
    run_frames(1, 200, 1'b0, 1'b1, to);
    enable = 1'b0;
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL mid_reset_refr_timeout got=%b want=0", to); end
    build_frame(8'h00, pl);
    nerr = 0;
    foreach (exp_q[i]) if (i >= ob.size() || ob[i] !== exp_q[i]) nerr++;
    checks++; if (nerr != 0 || ob.size() != 68) begin failures++; $display("FAIL mid_reset_new_frame mismatches=%0d len=%0d want=0/68", nerr, ob.size()); end
    checks++; if (frame_cnt !== 16'd1) begin failures++; $display("FAIL mid_reset_frame_cnt got=%0d want=1", frame_cnt); end
  endtask

  task automatic test_enable();
    logic [7:0] pl[$];
    bit to;
    int p0, k, nerr;
    enable = 1'b0;
    fq.delete();
    ob.delete();
    for (int j = 0; j < 74; j++) fq.push_back(8'(8'hC0 + j));
    for (int j = 0; j < 64; j++) pl.push_back(8'(8'hC0 + j));
    p0 = pops;
    for (int i = 0; i < 20; i++) cyc();
    checks++; if (ob.size() != 0 || busy !== 1'b0) begin failures++; $display("FAIL en_off_output bytes=%0d busy=%b want=0/0", ob.size(), busy); end
    checks++; if (pops != p0 || fq.size() != 74) begin failures++; $display("FAIL en_off_fifo pops=%0d size=%0d want=0/74", pops - p0, fq.size()); end
    enable = 1'b1;
    k = 0;
    while (ob.size() < 1 && k < 10) begin
      cyc();
      k++;
    end
    enable = 1'b0;
    checks++; if (busy !== 1'b1 || ob.size() != 1) begin failures++; $display("FAIL en_drop_in_hdr1 busy=%b bytes=%0d want=1/1", busy, ob.size()); end
    run_frames(1, 200, 1'b0, 1'b0, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL en_drop_timeout got=%b want=0", to); end
    build_frame(8'h01, pl);
    nerr = 0;
    foreach (exp_q[i]) if (i >= ob.size() || ob[i] !== exp_q[i]) nerr++;
    checks++; if (nerr != 0 || ob.size() != 68) begin failures++; $display("FAIL en_drop_frame mismatches=%0d len=%0d want=0/68", nerr, ob.size()); end
    for (int i = 0; i < 30; i++) cyc();
    checks++; if (ob.size() != 68 || busy !== 1'b0 || fq.size() != 10) begin failures++; $display("FAIL en_drop_stays_idle bytes=%0d busy=%b fifo=%0d want=68/0/10", ob.size(), busy, fq.size()); end
    checks++; if (frame_cnt !== 16'd2) begin failures++; $display("FAIL en_frame_cnt got=%0d want=2", frame_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    bus.m_ready = 1'b1;
    bus.fifo_rd_vld = 1'b0;
    bus.fifo_rd_data = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic();
    test_random_ready();
    test_timeout_pad();
    test_back_to_back();
    test_mid_frame_reset();
    test_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
